// File: rtl/sm_mac_pkg.sv
// sm_mac_pkg: shared constants and helpers for the sign-magnitude MAC array.
//   MODE_MUL / MODE_ACC : encoding of the per-beat mode bit
//   sm2tc / tc2sm       : sign-magnitude <-> two's-complement at width w (w <= 63)
//   sat_lim             : largest positive magnitude representable at width w
package sm_mac_pkg;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_ACC = 1'b1;

   // Sign-magnitude value held in the low w bits -> 64-bit two's complement.
   function automatic logic signed [63:0] sm2tc(input logic [63:0] sm, input int unsigned w);
      logic [63:0] mag;
      mag = sm & ~(64'd1 << (w - 1));
      return sm[w-1] ? -$signed(mag) : $signed(mag);
   endfunction

   // 64-bit two's complement -> sign-magnitude in the low w bits. Zero maps to +0.
   function automatic logic [63:0] tc2sm(input logic signed [63:0] tc, input int unsigned w);
      logic [63:0] mag;
      mag = tc[63] ? 64'(-tc) : 64'(tc);
      return tc[63] ? (mag | (64'd1 << (w - 1))) : mag;
   endfunction

   // Saturation bound: results are clamped to +/- sat_lim(w).
   function automatic logic [63:0] sat_lim(input int unsigned w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

endpackage

// File: rtl/sm_mac_lane.sv
// sm_mac_lane: one lane of the MAC array.
//   ld0        : capture operands a/b
//   ld1        : register the sign-magnitude product of the captured operands
//   ld2        : product leaves stage 1; update result (and accumulator in ACC mode)
//   mode, clr  : mode and accumulator-restart of the beat being consumed at ld2
//   result     : sign-magnitude result, ACC_WIDTH bits
//   ovf        : sticky saturation flag, cleared by a clr beat
module sm_mac_lane
   import sm_mac_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld0,
   input  logic                  ld1,
   input  logic                  ld2,
   input  logic                  mode,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  ovf
);

   localparam int MW = DATA_WIDTH - 1;
   localparam int PW = 2 * MW;
   localparam logic signed [ACC_WIDTH:0] LIM = $signed((ACC_WIDTH + 1)'(sat_lim(ACC_WIDTH)));

   logic [DATA_WIDTH-1:0]       op_a, op_b;
   logic [PW-1:0]               p_mag;
   logic                        p_sgn;
   logic signed [ACC_WIDTH-1:0] acc;

   logic [MW-1:0]               mag_a, mag_b;
   logic [ACC_WIDTH-1:0]        prod_sm;
   logic signed [63:0]          prod_tc;
   logic signed [ACC_WIDTH:0]   base, sum, sat;
   logic                        hit;
   logic [63:0]                 acc_sm;
   logic                        unused_ok;

   assign mag_a = op_a[MW-1:0];
   assign mag_b = op_b[MW-1:0];

   always_comb begin
      prod_sm = {p_sgn, (ACC_WIDTH - 1)'(p_mag)};
      prod_tc = sm2tc({{(64 - ACC_WIDTH){1'b0}}, prod_sm}, ACC_WIDTH);
      // One guard bit above the accumulator width catches overflow of the add.
      base    = clr ? '0 : {acc[ACC_WIDTH-1], acc};
      sum     = base + prod_tc[ACC_WIDTH:0];
      sat     = sum;
      hit     = 1'b0;
      if (sum > LIM) begin
         sat = LIM;
         hit = 1'b1;
      end else if (sum < -LIM) begin
         sat = -LIM;
         hit = 1'b1;
      end
      acc_sm = tc2sm({{(63 - ACC_WIDTH){sat[ACC_WIDTH]}}, sat}, ACC_WIDTH);
   end

   // Upper bits of the 64-bit helper results are always sign/zero fill.
   assign unused_ok = ^{prod_tc[63:ACC_WIDTH+1], acc_sm[63:ACC_WIDTH], sat[ACC_WIDTH]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         p_mag  <= '0;
         p_sgn  <= 1'b0;
         acc    <= '0;
         result <= '0;
         ovf    <= 1'b0;
      end else begin
         if (ld0) begin
            op_a <= a;
            op_b <= b;
         end
         if (ld1) begin
            p_mag <= PW'(mag_a) * PW'(mag_b);
            // A zero magnitude on either side forces +0.
            p_sgn <= (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]) & (|mag_a) & (|mag_b);
         end
         if (ld2) begin
            if (mode == MODE_ACC) begin
               acc    <= sat[ACC_WIDTH-1:0];
               ovf    <= (ovf & ~clr) | hit;
               result <= acc_sm[ACC_WIDTH-1:0];
            end else begin
               result <= prod_sm;
            end
         end
      end
   end

endmodule

// File: rtl/sm_mac_array.sv
// sm_mac_array: LANES-wide pipelined sign-magnitude multiply / saturating MAC.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : input beat handshake (in_ready = pipeline can advance)
//   a, b                 : LANES packed DATA_WIDTH sign-magnitude operands
//   mode, acc_clr        : per-beat mode (0 mul, 1 acc) and accumulator restart
//   out_valid / out_ready: result handshake
//   result, ovf          : LANES packed ACC_WIDTH results, per-lane sticky saturation
// Pipeline: operand capture -> product (stage 1) -> result/accumulate (stage 2).
// A beat accepted at edge k shows out_valid after edge k+2.
module sm_mac_array
   import sm_mac_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4,
   parameter int ACC_WIDTH  = 40
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] a,
   input  logic [LANES*DATA_WIDTH-1:0] b,
   input  logic                        mode,
   input  logic                        acc_clr,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*ACC_WIDTH-1:0]  result,
   output logic [LANES-1:0]            ovf
);

   localparam int STAGES = 3;

   generate
      if (ACC_WIDTH < 2 * DATA_WIDTH - 1) begin : g_bad_acc
         $error("sm_mac_array: ACC_WIDTH must be >= 2*DATA_WIDTH-1");
      end
      if (ACC_WIDTH > 62) begin : g_bad_wide
         $error("sm_mac_array: ACC_WIDTH must be <= 62");
      end
      if (DATA_WIDTH < 2) begin : g_bad_data
         $error("sm_mac_array: DATA_WIDTH must be >= 2");
      end
   endgenerate

   logic [STAGES:1] vld_pipe;
   logic [2:1]      mode_pipe, clr_pipe;
   logic            adv, ld0, ld1, ld2;

   // Whole pipeline advances together; a stalled output freezes everything.
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe[STAGES];
   assign ld0       = adv && in_valid;
   assign ld1       = adv && vld_pipe[1];
   assign ld2       = adv && vld_pipe[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         mode_pipe <= '0;
         clr_pipe  <= '0;
      end else if (adv) begin
         vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
         mode_pipe <= {mode_pipe[1], mode};
         // acc_clr only means something on accumulate beats.
         clr_pipe  <= {clr_pipe[1], acc_clr && (mode == MODE_ACC)};
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sm_mac_lane #(
         .DATA_WIDTH(DATA_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .ld0   (ld0),
         .ld1   (ld1),
         .ld2   (ld2),
         .mode  (mode_pipe[2]),
         .clr   (clr_pipe[2]),
         .a     (a[i*DATA_WIDTH +: DATA_WIDTH]),
         .b     (b[i*DATA_WIDTH +: DATA_WIDTH]),
         .result(result[i*ACC_WIDTH +: ACC_WIDTH]),
         .ovf   (ovf[i])
      );
   end

endmodule

// File: tb/tb_sm_mac_array.sv
// tb_sm_mac_array: two instances (ACC_WIDTH 40 and 31) driven by the same stimulus,
// checked against an arithmetic reference model plus directed vector tables.
module tb_sm_mac_array;

   localparam int DW = 16;
   localparam int L  = 4;
   localparam int WA = 40;
   localparam int WB = 31;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready, in_ready_b;
   logic            mode, acc_clr;
   logic            out_valid, out_valid_b, out_ready;
   logic [L*DW-1:0] a, b;
   logic [L*WA-1:0] res_a;
   logic [L*WB-1:0] res_b;
   logic [L-1:0]    ovf_a, ovf_b;

   always #5 clk = ~clk;

   sm_mac_array #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(WA)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .mode(mode), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .result(res_a), .ovf(ovf_a));

   sm_mac_array #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(WB)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .a(a), .b(b), .mode(mode), .acc_clr(acc_clr),
      .out_valid(out_valid_b), .out_ready(out_ready), .result(res_b), .ovf(ovf_b));

   int checks   = 0;
   int failures = 0;
   int n_out    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [L*WA-1:0] ra;
      logic [L*WB-1:0] rb;
      logic [L-1:0]    oa;
      logic [L-1:0]    ob;
   } exp_t;

   exp_t   expq[$];
   longint macc[2][L];
   bit     movf[2][L];

   function automatic longint enc(input longint v, input int w);
      return (v < 0) ? ((longint'(1) << (w - 1)) | -v) : v;
   endfunction

   function automatic void model_reset();
      expq.delete();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < L; i++) begin
            macc[k][i] = 0;
            movf[k][i] = 1'b0;
         end
   endfunction

   function automatic void model_beat(input logic [L*DW-1:0] av, input logic [L*DW-1:0] bv,
                                      input logic md, input logic cl);
      exp_t   e;
      int     ws[2];
      longint ma, mb, p, lim, s, r;
      ws[0] = WA;
      ws[1] = WB;
      for (int i = 0; i < L; i++) begin
         ma = longint'(av[i*DW +: DW-1]);
         mb = longint'(bv[i*DW +: DW-1]);
         p  = ma * mb;
         if (av[i*DW+DW-1] ^ bv[i*DW+DW-1]) p = -p;
         for (int k = 0; k < 2; k++) begin
            if (!md) begin
               r = enc(p, ws[k]);
            end else begin
               lim = (longint'(1) << (ws[k] - 1)) - 1;
               if (cl) begin
                  macc[k][i] = 0;
                  movf[k][i] = 1'b0;
               end
               s = macc[k][i] + p;
               if (s > lim) begin s = lim; movf[k][i] = 1'b1; end
               else if (s < -lim) begin s = -lim; movf[k][i] = 1'b1; end
               macc[k][i] = s;
               r = enc(s, ws[k]);
            end
            if (k == 0) begin
               e.ra[i*WA +: WA] = r[WA-1:0];
               e.oa[i]          = movf[0][i];
            end else begin
               e.rb[i*WB +: WB] = r[WB-1:0];
               e.ob[i]          = movf[1][i];
            end
         end
      end
      expq.push_back(e);
   endfunction

   // Monitor: compares every presented output against the queue head (so a
   // stalled output must also hold its value), pops on handoff, and feeds the
   // model with each accepted beat.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid) begin
            checks++;
            if (expq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output actual=%h required=none", res_a);
            end else begin
               e = expq[0];
               if (res_a !== e.ra || ovf_a !== e.oa || res_b !== e.rb || ovf_b !== e.ob || !out_valid_b) begin
                  failures++;
                  $display("FAIL out_beat actual=%h/%h %h/%h required=%h/%h %h/%h",
                           res_a, ovf_a, res_b, ovf_b, e.ra, e.oa, e.rb, e.ob);
               end
               if (out_ready) begin
                  void'(expq.pop_front());
                  n_out++;
               end
            end
         end
         if (in_valid && in_ready) model_beat(a, b, mode, acc_clr);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic run_beat(input logic [L*DW-1:0] av, input logic [L*DW-1:0] bv,
                           input logic md, input logic cl, output int lat,
                           output logic [L*WA-1:0] ra, output logic [L*WB-1:0] rb,
                           output logic [L-1:0] oa, output logic [L-1:0] ob);
      @(posedge clk); #1;
      a = av; b = bv; mode = md; acc_clr = cl; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      ra = res_a; rb = res_b; oa = ovf_a; ob = ovf_b;
   endtask

   task automatic drain();
      int n = 0;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (expq.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0", expq.size());
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [15:0]   a0;
      logic [15:0]   b0;
      logic          md;
      logic          cl;
      logic [WA-1:0] exp;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int              lat, sent, cyc, stalls, n0;
      bit              took;
      logic [L*WA-1:0] ra;
      logic [L*WB-1:0] rb;
      logic [L-1:0]    oa, ob;

      tbl[0]  = '{16'h8003, 16'h0005, 1'b0, 1'b0, 40'h800000000F};
      tbl[1]  = '{16'h8000, 16'h8007, 1'b0, 1'b0, 40'h0};
      tbl[2]  = '{16'h0004, 16'h8000, 1'b0, 1'b0, 40'h0};
      tbl[3]  = '{16'h0003, 16'h0004, 1'b1, 1'b1, 40'hC};
      tbl[4]  = '{16'h8005, 16'h0002, 1'b1, 1'b0, 40'h2};
      tbl[5]  = '{16'h8001, 16'h0007, 1'b1, 1'b0, 40'h8000000005};
      tbl[6]  = '{16'h0001, 16'h0001, 1'b1, 1'b1, 40'h1};
      tbl[7]  = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 40'h3FFF0001};
      tbl[8]  = '{16'h0001, 16'h0002, 1'b1, 1'b0, 40'h3};
      tbl[9]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'h3FFF0001};
      tbl[10] = '{16'hFFFF, 16'h7FFF, 1'b0, 1'b0, 40'h803FFF0001};

      rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; acc_clr = 1'b0;
      a = '0; b = '0; out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(out_valid), 0);
      chk("reset_result", 64'(|{res_a, res_b}), 0);
      chk("reset_ovf", 64'(|{ovf_a, ovf_b}), 0);
      chk("reset_in_ready", 64'(in_ready), 1);
      rst_n = 1'b1;

      // directed single-beat table, lane 0 at ACC_WIDTH 40
      for (int i = 0; i < 11; i++) begin
         run_beat({48'h0, tbl[i].a0}, {48'h0, tbl[i].b0}, tbl[i].md, tbl[i].cl, lat, ra, rb, oa, ob);
         chk($sformatf("tbl%0d_result", i), 64'(ra[WA-1:0]), 64'(tbl[i].exp));
         chk($sformatf("tbl%0d_ovf", i), 64'(oa[0]), 0);
         chk($sformatf("tbl%0d_latency", i), 64'(lat), 2);
      end

      // saturation at ACC_WIDTH 31, lane 1 small operands
      run_beat({32'h0, 16'h0002, 16'h7FFF}, {32'h0, 16'h0003, 16'h7FFF}, 1'b1, 1'b1, lat, ra, rb, oa, ob);
      chk("sat1_result", 64'(rb[WB-1:0]), 64'h3FFF0001);
      chk("sat1_ovf", 64'(ob[0]), 0);
      run_beat({32'h0, 16'h0002, 16'h7FFF}, {32'h0, 16'h0003, 16'h7FFF}, 1'b1, 1'b0, lat, ra, rb, oa, ob);
      chk("sat2_result", 64'(rb[WB-1:0]), 64'h3FFFFFFF);
      chk("sat2_ovf", 64'(ob[0]), 1);
      chk("sat2_lane1_result", 64'(rb[WB +: WB]), 64'd12);
      chk("sat2_lane1_ovf", 64'(ob[1]), 0);
      chk("sat2_wide_result", 64'(ra[WA-1:0]), 64'h7FFE0002);
      chk("sat2_wide_ovf", 64'(oa[0]), 0);
      run_beat({32'h0, 16'h0002, 16'hFFFF}, {32'h0, 16'h0003, 16'h7FFF}, 1'b1, 1'b0, lat, ra, rb, oa, ob);
      chk("sat3_result", 64'(rb[WB-1:0]), 64'hFFFE);
      chk("sat3_ovf_sticky", 64'(ob[0]), 1);
      run_beat({32'h0, 16'h0002, 16'h0001}, {32'h0, 16'h0003, 16'h0001}, 1'b1, 1'b1, lat, ra, rb, oa, ob);
      chk("sat4_result", 64'(rb[WB-1:0]), 64'h1);
      chk("sat4_ovf_cleared", 64'(ob), 0);
      drain();

      // backpressure: 6 continuous accumulate beats, out_ready low 3 cycles
      sent = 0; cyc = 0; stalls = 0; took = 1'b1; n0 = n_out;
      while (sent < 6 && cyc < 40) begin
         @(posedge clk); #1;
         if (took) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            acc_clr = (sent == 0);
         end
         mode = 1'b1;
         in_valid  = 1'b1;
         out_ready = !(cyc >= 3 && cyc < 6);
         @(negedge clk);
         if (out_valid && !out_ready) begin
            stalls++;
            chk("stall_in_ready", 64'({in_ready, in_ready_b}), 0);
         end
         took = in_valid && in_ready;
         if (took) sent++;
         cyc++;
      end
      drain();
      chk("bp_beats_out", 64'(n_out - n0), 6);
      chk("bp_stall_seen", 64'(stalls != 0), 1);

      // randomized traffic with random backpressure
      for (int c = 0; c < 80; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(3) != 0);
         mode      = 1'($urandom_range(1));
         acc_clr   = ($urandom_range(4) == 0);
         a         = {$urandom(), $urandom()};
         b         = {$urandom(), $urandom()};
         out_ready = ($urandom_range(2) != 0);
      end
      drain();

      // reset with two beats in flight
      n0 = n_out;
      @(posedge clk); #1;
      a = 64'h5; b = 64'h6; mode = 1'b1; acc_clr = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      a = 64'h7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_out_valid", 64'({out_valid, out_valid_b}), 0);
      chk("midrst_result", 64'(|{res_a, res_b}), 0);
      chk("midrst_ovf", 64'(|{ovf_a, ovf_b}), 0);
      repeat (3) @(posedge clk);
      chk("midrst_no_output", 64'(n_out - n0), 0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("postrst_in_ready", 64'(in_ready), 1);
      run_beat(64'h3, 64'h4, 1'b1, 1'b0, lat, ra, rb, oa, ob);
      chk("postrst_acc_from_zero", 64'(ra[WA-1:0]), 64'hC);
      chk("postrst_acc_from_zero_b", 64'(rb[WB-1:0]), 64'hC);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
